// File: rtl/bsg_fsb_node_iso_pkg.sv
// Shared types and helpers for the FSB node isolation sequencer.
//   bsg_fsb_node_iso_state_e : 2-bit FSM state encoding (also driven on state_o)
//   ctr_width()              : counter width for the wake/drain counters
package bsg_fsb_node_iso_pkg;

  typedef enum logic [1:0] {
    ST_ISOLATED = 2'd0,
    ST_WAKE     = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_DRAIN    = 2'd3
  } bsg_fsb_node_iso_state_e;

  // Wide enough to hold the larger of the wake delay and the drain timeout.
  function automatic int unsigned ctr_width(input int unsigned wake_delay,
                                            input int unsigned drain_timeout);
    int unsigned m;
    m = (wake_delay > drain_timeout) ? wake_delay : drain_timeout;
    return $clog2(m + 1);
  endfunction

  localparam int unsigned CTR_W_DEFAULT = ctr_width(4, 16);

endpackage

// File: rtl/bsg_fsb_node_iso_gate.sv
// One direction of valid/data/handshake gating.
//   v_i, data_i  : forward valid and data from the source side
//   hs_i         : handshake (ready/yumi) from the sink side
//   en_v_i       : enable for valid and data
//   en_hs_i      : enable for the returning handshake
//   v_o, data_o  : gated valid and data toward the sink
//   hs_o         : gated handshake toward the source
module bsg_fsb_node_iso_gate #(
  parameter int unsigned width_p = 80
) (
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               hs_i,
  input  logic               en_v_i,
  input  logic               en_hs_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               hs_o
);

  assign v_o    = v_i & en_v_i;
  assign data_o = data_i & {width_p{en_v_i}};
  assign hs_o   = hs_i & en_hs_i;

endmodule

// File: rtl/bsg_fsb_node_iso_seq.sv
// Sequenced isolation / level-shift controller for one FSB node power domain.
//   clk_i, reset_n_i            : clock, async active-low reset
//   pwr_good_i, iso_req_i       : node supply good, isolation request (pre-synchronized)
//   en_ls_o, node_reset_o       : registered level-shifter enable and node reset
//   state_o                     : current FSM state
//   drain_timeout_o, abort_o    : one-cycle event pulses
//   fsb_*_o_i -> node_*_i_o     : FSB-to-node traffic (valid/data), node ready back
//   node_*_o_i -> fsb_*_i_o     : node-to-FSB traffic (valid/data), FSB yumi back
module bsg_fsb_node_iso_seq
  import bsg_fsb_node_iso_pkg::*;
#(
  parameter int unsigned width_p         = 80,
  parameter int unsigned wake_delay_p    = 4,
  parameter int unsigned idle_cycles_p   = 2,
  parameter int unsigned drain_timeout_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               pwr_good_i,
  input  logic               iso_req_i,
  output logic               en_ls_o,
  output logic               node_reset_o,
  output logic [1:0]         state_o,
  output logic               drain_timeout_o,
  output logic               abort_o,

  input  logic               fsb_v_o_i,
  input  logic [width_p-1:0] fsb_data_o_i,
  input  logic               fsb_yumi_o_i,
  output logic               node_v_i_o,
  output logic [width_p-1:0] node_data_i_o,
  output logic               node_yumi_i_o,

  input  logic               node_v_o_i,
  input  logic [width_p-1:0] node_data_o_i,
  input  logic               node_ready_o_i,
  output logic               fsb_v_i_o,
  output logic [width_p-1:0] fsb_data_i_o,
  output logic               fsb_ready_i_o
);

  localparam int unsigned CW = ctr_width(wake_delay_p, drain_timeout_p);

  bsg_fsb_node_iso_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;    // wake countdown in WAKE, timeout count in DRAIN
  logic [CW-1:0] idle_q, idle_d;
  logic          abort_q, abort_d;
  logic          tmo_q, tmo_d;
  logic          en_ls_q, node_reset_q;
  logic          fwd_en_q, rev_en_q;
  logic [CW-1:0] idle_inc, tmo_inc;

  always_comb begin
    idle_inc = node_v_o_i ? '0 : ((idle_q == '1) ? idle_q : idle_q + 1'b1);
    tmo_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    abort_d = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_ISOLATED: begin
        cnt_d  = '0;
        idle_d = '0;
        if (pwr_good_i && !iso_req_i) begin
          state_d = ST_WAKE;
          cnt_d   = CW'(wake_delay_p - 1);
        end
      end
      ST_WAKE: begin
        if (!pwr_good_i) begin
          state_d = ST_ISOLATED;
          abort_d = 1'b1;
        end else if (iso_req_i) begin
          state_d = ST_ISOLATED;
        end else if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!pwr_good_i) begin
          state_d = ST_ISOLATED;
          abort_d = 1'b1;
        end else if (iso_req_i) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          idle_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (!pwr_good_i) begin
          state_d = ST_ISOLATED;
          abort_d = 1'b1;
        end else if (!iso_req_i) begin
          state_d = ST_ACTIVE;
        end else begin
          // Exit decisions use this cycle's updated counts so DRAIN lasts
          // exactly idle_cycles_p idle cycles or drain_timeout_p cycles.
          idle_d = idle_inc;
          cnt_d  = tmo_inc;
          if (idle_inc >= CW'(idle_cycles_p)) begin
            state_d = ST_ISOLATED;
          end else if (tmo_inc >= CW'(drain_timeout_p)) begin
            state_d = ST_ISOLATED;
            tmo_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_ISOLATED;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_ISOLATED;
      cnt_q        <= '0;
      idle_q       <= '0;
      abort_q      <= 1'b0;
      tmo_q        <= 1'b0;
      en_ls_q      <= 1'b0;
      node_reset_q <= 1'b1;
      fwd_en_q     <= 1'b0;
      rev_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      abort_q      <= abort_d;
      tmo_q        <= tmo_d;
      en_ls_q      <= (state_d != ST_ISOLATED);
      node_reset_q <= (state_d == ST_ISOLATED) || (state_d == ST_WAKE);
      fwd_en_q     <= (state_d == ST_ACTIVE);
      rev_en_q     <= (state_d == ST_ACTIVE) || (state_d == ST_DRAIN);
    end
  end

  assign state_o         = state_q;
  assign en_ls_o         = en_ls_q;
  assign node_reset_o    = node_reset_q;
  assign abort_o         = abort_q;
  assign drain_timeout_o = tmo_q;

  // FSB to node: closed during DRAIN so no new traffic reaches the node.
  bsg_fsb_node_iso_gate #(.width_p(width_p)) u_gate_fwd (
    .v_i     (fsb_v_o_i),
    .data_i  (fsb_data_o_i),
    .hs_i    (node_ready_o_i),
    .en_v_i  (fwd_en_q),
    .en_hs_i (fwd_en_q),
    .v_o     (node_v_i_o),
    .data_o  (node_data_i_o),
    .hs_o    (fsb_ready_i_o)
  );

  // Node to FSB: stays open through DRAIN so the node can empty.
  bsg_fsb_node_iso_gate #(.width_p(width_p)) u_gate_rev (
    .v_i     (node_v_o_i),
    .data_i  (node_data_o_i),
    .hs_i    (fsb_yumi_o_i),
    .en_v_i  (rev_en_q),
    .en_hs_i (rev_en_q),
    .v_o     (fsb_v_i_o),
    .data_o  (fsb_data_i_o),
    .hs_o    (node_yumi_i_o)
  );

endmodule

// File: doc/bsg_fsb_node_iso_seq.md
Name: bsg_fsb_node_iso_seq

Overview:
- Sequenced isolation/level-shift controller for one FSB node power domain, width-parametrised.
- Replaces the static en_ls_i gate with an FSM: power-up wake delay, held node reset, graceful drain before isolation, and abort on power loss.
- Sits between the FSB ring and the node. Owns en_ls and the node reset. Gates both valid/ready directions and all data from registered enables.

Parameters:
- width_p, 80, FSB data width in bits.
- wake_delay_p, 4, cycles in WAKE (shifters enabled, node in reset) before ACTIVE; must be >=1.
- idle_cycles_p, 2, consecutive cycles with node_v_o_i=0 required to finish DRAIN; must be >=1.
- drain_timeout_p, 16, maximum DRAIN cycles before forced isolation; must be > idle_cycles_p.

Ports:
- clk_i  in  1  single clock
- reset_n_i  in  1  asynchronous, active-low reset
- pwr_good_i  in  1  node supply good; synchronous to clk_i
- iso_req_i  in  1  level request to isolate/power down node
- en_ls_o  out  1  level-shifter enable (registered)
- node_reset_o  out  1  node-domain reset, active-high (registered)
- state_o  out  2  current FSM state
- drain_timeout_o  out  1  one-cycle pulse: DRAIN ended by timeout
- abort_o  out  1  one-cycle pulse: pwr_good_i lost in WAKE/ACTIVE/DRAIN
- fsb_v_o_i, fsb_data_o_i[width_p], fsb_yumi_o_i  in  FSB to node direction
- node_v_i_o, node_data_i_o[width_p], node_yumi_i_o  out  toward node
- node_v_o_i, node_data_o_i[width_p], node_ready_o_i  in  node to FSB direction
- fsb_v_i_o, fsb_data_i_o[width_p], fsb_ready_i_o  out  toward FSB

Behaviour:
- States: ISOLATED=0, WAKE=1, ACTIVE=2, DRAIN=3.
- Reset (reset_n_i low, async): ISOLATED, counter=0, en_ls_o=0, node_reset_o=1, pulses=0.
  - Every gated output is 0 in reset: node_v_i_o, node_yumi_i_o, node_data_i_o, fsb_v_i_o, fsb_ready_i_o, fsb_data_i_o.
- ISOLATED: en_ls=0, node_reset=1, all gated outputs 0.
  - pwr_good_i && !iso_req_i -> WAKE; counter loaded with wake_delay_p-1.
- WAKE: en_ls=1, node_reset=1, all gated outputs still 0.
  - !pwr_good_i -> ISOLATED and pulse abort_o.
  - Else iso_req_i -> ISOLATED, no pulse.
  - Else counter==0 -> ACTIVE; otherwise decrement.
  - ACTIVE is entered exactly wake_delay_p cycles after WAKE entry.
- ACTIVE: en_ls=1, node_reset=0, full pass-through.
  - Each output equals its input ANDed with the registered enable.
  - !pwr_good_i -> ISOLATED and pulse abort_o; takes priority over iso_req_i.
  - Else iso_req_i -> DRAIN; idle counter=0, timeout counter=0.
- DRAIN: en_ls=1, node_reset=0.
  - FSB to node blocked: node_v_i_o=0, fsb_ready_i_o=0, so no new traffic enters the node.
  - Node to FSB still passes: fsb_v_i_o, fsb_data_i_o, node_yumi_i_o.
  - idle counter increments when node_v_o_i=0; clears when node_v_o_i=1. Timeout counter increments every cycle.
  - Transition priority, highest first:
    1. !pwr_good_i -> ISOLATED, abort_o.
    2. !iso_req_i -> ACTIVE (cancel).
    3. idle count reaches idle_cycles_p -> ISOLATED.
    4. timeout count reaches drain_timeout_p -> ISOLATED, drain_timeout_o pulse.
  - If 3 and 4 occur in the same cycle, idle wins: no timeout pulse.
- Outputs: en_ls_o and node_reset_o are registered from the next state, so they change in the same edge as state_o.
- Data gating: combinational from the registered enables. No data storage, zero latency.
- Counter width: $clog2(max(wake_delay_p, drain_timeout_p)+1). Counters saturate and never wrap.
- Outputs are undefined only for X inputs. pwr_good_i and iso_req_i are required to be synchronized upstream.

Decomposition:
- Package bsg_fsb_node_iso_pkg:
  - state enum bsg_fsb_node_iso_state_e (2-bit).
  - localparam for counter width computation.
- Sub-module bsg_fsb_node_iso_gate (width_p, enable): one v/data/handshake gate. Instantiated twice, once per direction, with separate valid and ready enables.

Test Plan:
- Power-up: reset_n_i low, then high; pwr_good_i=1, iso_req_i=0, wake_delay_p=4.
  -> state_o ISOLATED, WAKE, then ACTIVE 4 cycles later; node_reset_o falls on the same edge.
  -> node_data_i_o=fsb_data_o_i when ACTIVE, 0 before.
- Graceful drain: in ACTIVE, raise iso_req_i; node_v_o_i=1 for 3 cycles, then 0.
  -> node_v_i_o=0 and fsb_ready_i_o=0 immediately; fsb_v_i_o follows node_v_o_i.
  -> ISOLATED 2 cycles after node_v_o_i falls; drain_timeout_o stays 0.
- Drain timeout: iso_req_i=1, node_v_o_i held 1.
  -> exactly 16 DRAIN cycles, then ISOLATED with a single drain_timeout_o pulse; en_ls_o=0.
- Drain cancel: during DRAIN drop iso_req_i.
  -> ACTIVE next cycle; node_v_i_o passes again; no pulses.
- Power loss: drop pwr_good_i in WAKE, ACTIVE and DRAIN.
  -> ISOLATED next edge, one abort_o pulse each time; all gated outputs 0.
- Async reset mid-ACTIVE: assert reset_n_i low between edges.
  -> en_ls_o=0, node_reset_o=1, all gated outputs 0 without a clock edge.
